// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_pkg
//  Description : Shared types and constants for the two-car dispatcher.
//  Revision    : 1.0  initial release
// ============================================================================
package elevator_pkg;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_e;

    localparam logic       REQ_UP   = 1'b1;
    localparam logic       REQ_DOWN = 1'b0;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_L1   = 2'b01;
    localparam logic [1:0] SEL_L2   = 2'b10;

endpackage
`default_nettype wire

// File: rtl/lift_cost_calc.sv
`default_nettype none
// ============================================================================
//  Module      : lift_cost_calc
//  Description : Per-car direction, suitability and service cost for one call.
//  Revision    : 1.0  initial release
// ============================================================================
module lift_cost_calc
    import elevator_pkg::*;
#(
    parameter int FLOOR_W = 3
) (
    input  logic [FLOOR_W-1:0] curr,
    input  logic [FLOOR_W-1:0] dest,
    input  logic [FLOOR_W-1:0] req_floor,
    input  logic               req_direction,
    output logic [1:0]         dir,
    output logic               suitable,
    output logic [FLOOR_W:0]   cost
);

    function automatic logic [FLOOR_W-1:0] abs_diff(
        input logic [FLOOR_W-1:0] a,
        input logic [FLOOR_W-1:0] b
    );
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    dir_e               w_dir;
    logic [FLOOR_W-1:0] w_d_curr_req;
    logic [FLOOR_W-1:0] w_d_curr_dest;
    logic [FLOOR_W-1:0] w_d_dest_req;

    always_comb begin
        w_dir = DIR_IDLE;
        if (dest > curr) begin
            w_dir = DIR_UP;
        end else if (dest < curr) begin
            w_dir = DIR_DOWN;
        end
    end

    // A moving car only counts as suitable if the call is ahead of it in its travel direction.
    always_comb begin
        suitable = 1'b0;
        case (w_dir)
            DIR_IDLE: suitable = 1'b1;
            DIR_UP:   suitable = (req_direction == REQ_UP)   && (curr <= req_floor);
            DIR_DOWN: suitable = (req_direction == REQ_DOWN) && (curr >= req_floor);
            default:  suitable = 1'b0;
        endcase
    end

    assign w_d_curr_req  = abs_diff(curr, req_floor);
    assign w_d_curr_dest = abs_diff(curr, dest);
    assign w_d_dest_req  = abs_diff(dest, req_floor);

    always_comb begin
        if (suitable) begin
            cost = {1'b0, w_d_curr_req};
        end else begin
            cost = {1'b0, w_d_curr_dest} + {1'b0, w_d_dest_req};
        end
    end

    assign dir = w_dir;

endmodule
`default_nettype wire

// File: rtl/elevator_controller.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_controller
//  Description : Two-car hall-call dispatcher with a registered car selection.
//  Revision    : 1.0  initial release
// ============================================================================
module elevator_controller
    import elevator_pkg::*;
#(
    parameter int FLOOR_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FLOOR_W-1:0] curr_floor_L1,
    input  logic [FLOOR_W-1:0] curr_floor_L2,
    input  logic [FLOOR_W-1:0] dest_floor_L1,
    input  logic [FLOOR_W-1:0] dest_floor_L2,
    input  logic [FLOOR_W-1:0] req_floor,
    input  logic               req_direction,
    output logic [1:0]         selected_lift
);

    logic [1:0]       w_dir_l1;
    logic [1:0]       w_dir_l2;
    logic             w_suit_l1;
    logic             w_suit_l2;
    logic [FLOOR_W:0] w_cost_l1;
    logic [FLOOR_W:0] w_cost_l2;
    logic [1:0]       w_sel;
    logic [1:0]       r_selected_lift;

    lift_cost_calc #(
        .FLOOR_W (FLOOR_W)
    ) u_cost_l1 (
        .curr          (curr_floor_L1),
        .dest          (dest_floor_L1),
        .req_floor     (req_floor),
        .req_direction (req_direction),
        .dir           (w_dir_l1),
        .suitable      (w_suit_l1),
        .cost          (w_cost_l1)
    );

    lift_cost_calc #(
        .FLOOR_W (FLOOR_W)
    ) u_cost_l2 (
        .curr          (curr_floor_L2),
        .dest          (dest_floor_L2),
        .req_floor     (req_floor),
        .req_direction (req_direction),
        .dir           (w_dir_l2),
        .suitable      (w_suit_l2),
        .cost          (w_cost_l2)
    );

    // Car 1 wins unless car 2 is strictly cheaper, or equally cheap and uniquely suitable.
    always_comb begin
        w_sel = SEL_L1;
        if (w_cost_l2 < w_cost_l1) begin
            w_sel = SEL_L2;
        end else if ((w_cost_l2 == w_cost_l1) && w_suit_l2 && !w_suit_l1) begin
            w_sel = SEL_L2;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_selected_lift <= SEL_NONE;
        end else begin
            r_selected_lift <= w_sel;
        end
    end

    assign selected_lift = r_selected_lift;

    always_comb begin
        assert ((w_dir_l1 != DIR_IDLE) || w_suit_l1);
        assert ((w_dir_l2 != DIR_IDLE) || w_suit_l2);
    end

endmodule
`default_nettype wire

// File: tb/tb_elevator_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_elevator_controller
//  Description : Directed and random checks of the dispatcher against a rule model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_elevator_controller;

    localparam int FLOOR_W = 3;
    localparam int TOP_FLOOR = (1 << FLOOR_W) - 1;

    logic               clk = 1'b0;
    logic               reset;
    logic [FLOOR_W-1:0] c1, c2, d1, d2, rf;
    logic               rd;
    logic [1:0]         sel;

    int         total = 0;
    int         bad   = 0;
    logic [1:0] exp_sel = 2'b00;
    bit         model_valid = 1'b0;

    elevator_controller #(.FLOOR_W(FLOOR_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .curr_floor_L1 (c1),
        .curr_floor_L2 (c2),
        .dest_floor_L1 (d1),
        .dest_floor_L2 (d2),
        .req_floor     (rf),
        .req_direction (rd),
        .selected_lift (sel)
    );

    always #5 clk = ~clk;

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic void car_cost(input int c, input int d, input int r, input bit up,
                                     output bit s, output int k);
        s = (d == c) || (d > c && up && c <= r) || (d < c && !up && c >= r);
        k = s ? iabs(c - r) : iabs(c - d) + iabs(d - r);
    endfunction

    function automatic logic [1:0] model_sel(input int a1, input int b1, input int a2,
                                             input int b2, input int r, input bit up);
        bit s1, s2;
        int k1, k2;
        car_cost(a1, b1, r, up, s1, k1);
        car_cost(a2, b2, r, up, s2, k2);
        if (k1 < k2) return 2'b01;
        if (k2 < k1) return 2'b10;
        if (s2 && !s1) return 2'b10;
        return 2'b01;
    endfunction

    // Reference: what the register must hold after each rising edge.
    always @(posedge clk) begin
        if (!reset) exp_sel = 2'b00;
        else        exp_sel = model_sel(int'(c1), int'(d1), int'(c2), int'(d2), int'(rf), rd);
        model_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            total++;
            if (sel !== exp_sel) begin
                bad++;
                $display("FAIL cycle_cmp t=%0t got=%b want=%b (L1 %0d->%0d L2 %0d->%0d req %0d dir %0d rst %0d)",
                         $time, sel, exp_sel, c1, d1, c2, d2, rf, rd, reset);
            end
        end
    end

    task automatic check(input string name, input logic [1:0] got, input logic [1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%b want=%b", name, got, want);
        end
    endtask

    task automatic set_in(input int a1, input int b1, input int a2, input int b2,
                          input int r, input bit up);
        c1 = FLOOR_W'(a1); d1 = FLOOR_W'(b1);
        c2 = FLOOR_W'(a2); d2 = FLOOR_W'(b2);
        rf = FLOOR_W'(r);  rd = up;
    endtask

    task automatic run_vec(input string name, input int a1, input int b1, input int a2,
                           input int b2, input int r, input bit up, input logic [1:0] want);
        @(negedge clk);
        set_in(a1, b1, a2, b2, r, up);
        @(posedge clk);
        #1;
        check({name, "_model"}, exp_sel, want);
        check(name, sel, want);
    endtask

    initial begin
        reset = 1'b0;
        set_in(5, 2, 7, 6, 3, 0);
        @(posedge clk); #1;
        check("reset_edge1", sel, 2'b00);
        @(posedge clk); #1;
        check("reset_edge2", sel, 2'b00);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("release", sel, 2'b01);

        run_vec("both_suit",       5, 2, 7, 6, 3, 0, 2'b01);
        run_vec("l1_unsuit",       5, 0, 1, 2, 3, 1, 2'b10);
        run_vec("up_4v3",          1, 6, 2, 7, 5, 1, 2'b10);
        run_vec("up_4v6",          1, 3, 7, 3, 5, 1, 2'b01);
        run_vec("tie_unsuit_a",    4, 7, 2, 0, 4, 0, 2'b01);
        run_vec("tie_unsuit_b",    5, 2, 3, 1, 5, 1, 2'b01);
        run_vec("l2_idle_at_req",  0, 7, 2, 2, 2, 0, 2'b10);
        run_vec("identical",       3, 3, 3, 3, 3, 1, 2'b01);
        run_vec("suit_breaks_tie", 4, 3, 2, 2, 3, 1, 2'b10);
        run_vec("floor0",          TOP_FLOOR, TOP_FLOOR, 0, 0, 0, 0, 2'b10);
        run_vec("floor_top",       0, TOP_FLOOR, TOP_FLOOR, TOP_FLOOR, TOP_FLOOR, 1, 2'b10);

        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("midrun_reset", sel, 2'b00);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrun_release", sel, 2'b10);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 63) != 0);
            if ($urandom_range(0, 2) == 0) begin
                set_in($urandom_range(2, 5), $urandom_range(2, 5), $urandom_range(2, 5),
                       $urandom_range(2, 5), $urandom_range(2, 5), 1'($urandom_range(0, 1)));
            end else begin
                set_in($urandom_range(0, TOP_FLOOR), $urandom_range(0, TOP_FLOOR),
                       $urandom_range(0, TOP_FLOOR), $urandom_range(0, TOP_FLOOR),
                       $urandom_range(0, TOP_FLOOR), 1'($urandom_range(0, 1)));
            end
        end
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
